// File: rtl/dsp_mac_pipe.sv
// Two-stage signed MAC: M = A*B registered, then a P_WIDTH post-adder/accumulator; latency 2 CE-enabled edges.
// CE low freezes every register, including the valid bits. Optional sticky OVERFLOW port under `DSP_OVERFLOW_EN.
module dsp_mac_pipe #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      CE,
  input  logic                      IN_VALID,
  input  logic signed [A_WIDTH-1:0] A,
  input  logic signed [B_WIDTH-1:0] B,
  input  logic        [P_WIDTH-1:0] C,
  input  logic        [1:0]         OPMODE,
  output logic        [P_WIDTH-1:0] P,
  output logic                      CARRYOUT,
  output logic                      OUT_VALID
`ifdef DSP_OVERFLOW_EN
  ,
  output logic                      OVERFLOW
`endif
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [M_WIDTH-1:0] m_q, m_d;
  logic        [P_WIDTH-1:0] c_q;
  logic        [1:0]         op_q;
  logic                      vld_q;
  logic        [P_WIDTH-1:0] p_q, p_d;
  logic                      co_q, co_d;
  logic                      out_vld_q;

  logic [P_WIDTH-1:0] ms;
  logic [P_WIDTH-1:0] add_x, add_y;
  logic               add_cin;
  logic [P_WIDTH:0]   sum;

  always_comb m_d = M_WIDTH'(A) * M_WIDTH'(B);

  assign ms = {{(P_WIDTH - M_WIDTH + 1){m_q[M_WIDTH-1]}}, m_q[M_WIDTH-2:0]};

  // Subtract is C + ~Ms + 1, so the top carry is directly the no-borrow flag.
  always_comb begin
    add_x   = '0;
    add_y   = ms;
    add_cin = 1'b0;
    case (op_q)
      2'b00: add_x = '0;
      2'b01: add_x = p_q;
      2'b10: add_x = c_q;
      default: begin
        add_x   = c_q;
        add_y   = ~ms;
        add_cin = 1'b1;
      end
    endcase
    sum  = {1'b0, add_x} + {1'b0, add_y} + {{P_WIDTH{1'b0}}, add_cin};
    p_d  = sum[P_WIDTH-1:0];
    co_d = (op_q == 2'b00) ? 1'b0 : sum[P_WIDTH];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_q       <= '0;
      c_q       <= '0;
      op_q      <= '0;
      vld_q     <= 1'b0;
      p_q       <= '0;
      co_q      <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (CE) begin
      m_q       <= m_d;
      c_q       <= C;
      op_q      <= OPMODE;
      vld_q     <= IN_VALID;
      out_vld_q <= vld_q;
      if (vld_q) begin
        p_q  <= p_d;
        co_q <= co_d;
      end
    end
  end

  assign P         = p_q;
  assign CARRYOUT  = co_q;
  assign OUT_VALID = out_vld_q;

`ifdef DSP_OVERFLOW_EN
  logic [P_WIDTH-1:0] ovf_y;
  logic               ovf_hit;
  logic               ovf_q, ovf_d;

  // Signed overflow: same-sign operands, result sign differs; the subtract's true operand is -Ms.
  always_comb begin
    ovf_y   = (op_q == 2'b11) ? ({P_WIDTH{1'b0}} - ms) : ms;
    ovf_hit = (add_x[P_WIDTH-1] == ovf_y[P_WIDTH-1]) && (p_d[P_WIDTH-1] != add_x[P_WIDTH-1]);
    ovf_d   = (op_q == 2'b00) ? 1'b0 : (ovf_q | ovf_hit);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
    end else if (CE && vld_q) begin
      ovf_q <= ovf_d;
    end
  end

  assign OVERFLOW = ovf_q;
`endif

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: a signed-integer reference model feeds an expectation queue,
// and an independent monitor checks every edge (valid pulses, latency, holds during stalls and bubbles).
module tb_dsp_mac_pipe;

  localparam int PW = 48;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               CE = 1'b0;
  logic               IN_VALID = 1'b0;
  logic signed [17:0] A = '0;
  logic signed [17:0] B = '0;
  logic [PW-1:0]      C = '0;
  logic [1:0]         OPMODE = '0;
  logic [PW-1:0]      P;
  logic               CARRYOUT;
  logic               OUT_VALID;
  logic               OVERFLOW;

  dsp_mac_pipe dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .C(C), .OPMODE(OPMODE),
    .P(P), .CARRYOUT(CARRYOUT), .OUT_VALID(OUT_VALID)
`ifdef DSP_OVERFLOW_EN
    , .OVERFLOW(OVERFLOW)
`endif
  );

`ifndef DSP_OVERFLOW_EN
  assign OVERFLOW = 1'b0;
`endif

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PW-1:0] p;
    logic          co;
    logic          ov;
    int            due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   ecount = 0;

  // reference state
  logic [PW-1:0] mp = '0;
  logic          movf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level model: signed/unsigned integer arithmetic on 64-bit values, wrapped to PW bits.
  task automatic model(input logic signed [17:0] a, input logic signed [17:0] b,
                       input logic [PW-1:0] c, input logic [1:0] opm,
                       output logic [PW-1:0] r, output logic co);
    longint prod, sp, sc, t, ums, ump, uc, lim_hi, lim_lo, two48;
    logic [63:0] pv;
    logic [PW-1:0] ms;
    bit ov;
    prod   = longint'(a) * longint'(b);
    pv     = prod;
    ms     = pv[PW-1:0];
    sp     = longint'($signed(mp));
    sc     = longint'($signed(c));
    ums    = longint'({16'b0, ms});
    ump    = longint'({16'b0, mp});
    uc     = longint'({16'b0, c});
    two48  = longint'(1) <<< 48;
    lim_hi = (longint'(1) <<< 47) - 1;
    lim_lo = -(longint'(1) <<< 47);
    ov     = 1'b0;
    t      = 0;
    case (opm)
      2'b00: begin r = ms; co = 1'b0; end
      2'b01: begin r = mp + ms; co = (ump + ums) >= two48; t = sp + prod; end
      2'b10: begin r = c + ms;  co = (uc + ums) >= two48;  t = sc + prod; end
      default: begin r = c - ms; co = uc >= ums; t = sc - prod; end
    endcase
    if (opm != 2'b00) ov = (t > lim_hi) || (t < lim_lo);
    movf = (opm == 2'b00) ? 1'b0 : (movf | ov);
    mp   = r;
  endtask

  task automatic drive(input bit ce, input bit v, input logic signed [17:0] a,
                       input logic signed [17:0] b, input logic [PW-1:0] c, input logic [1:0] opm,
                       input bit chk_p = 0, input logic [PW-1:0] xp = '0,
                       input bit chk_co = 0, input bit xco = 0);
    exp_t e;
    logic [PW-1:0] r;
    logic co;
    @(posedge CLK);
    #1;
    CE = ce; IN_VALID = v; A = a; B = b; C = c; OPMODE = opm;
    if (ce && v) begin
      model(a, b, c, opm, r, co);
      e.p   = chk_p ? xp : r;
      e.co  = chk_co ? xco : co;
      e.ov  = movf;
      e.due = ecount + 2;
      q.push_back(e);
    end
  endtask

  // Monitor: counts enabled edges and checks outputs half a cycle later.
  initial begin
    logic [PW-1:0] held_p;
    logic held_co, held_ov, last_ov;
    bit en, exp_v;
    exp_t e;
    held_p = '0; held_co = 0; held_ov = 0; last_ov = 0;
    forever begin
      @(posedge CLK);
      en = CE && RST_N;
      if (en) ecount++;
      @(negedge CLK);
      if (!RST_N) begin
        held_p = '0; held_co = 0; held_ov = 0; last_ov = 0;
        continue;
      end
      if (en) begin
        exp_v = (q.size() > 0) && (q[0].due == ecount);
        check("out_valid", 64'(OUT_VALID), 64'(exp_v));
        if (exp_v) begin
          e = q.pop_front();
          check("p", 64'(P), 64'(e.p));
          check("carryout", 64'(CARRYOUT), 64'(e.co));
`ifdef DSP_OVERFLOW_EN
          check("overflow", 64'(OVERFLOW), 64'(e.ov));
          held_ov = e.ov;
`endif
          held_p = e.p; held_co = e.co;
        end else begin
          check("p_hold", 64'(P), 64'(held_p));
          check("co_hold", 64'(CARRYOUT), 64'(held_co));
        end
        last_ov = exp_v;
      end else begin
        check("stall_valid", 64'(OUT_VALID), 64'(last_ov));
        check("stall_p", 64'(P), 64'(held_p));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [17:0] ra, rb;
    logic [PW-1:0] rc;
    logic [63:0] r64;
    #2;
    check("reset_p", 64'(P), 64'd0);
    check("reset_valid", 64'(OUT_VALID), 64'd0);
    @(posedge CLK); #1; RST_N = 1'b1;

    // load / accumulate back-to-back
    drive(1, 1, 18'sd3, 18'sd4, '0, 2'b00, 1, 48'd12);
    drive(1, 1, -18'sd2, 18'sd5, '0, 2'b01, 1, 48'd2);
    drive(1, 1, 18'sd1, 18'sd1, '0, 2'b01, 1, 48'd3, 1, 1'b0);
    // C paths
    drive(1, 1, 18'sd6, 18'sd7, 48'd100, 2'b10, 1, 48'd142, 1, 1'b0);
    drive(1, 1, 18'sd2, 18'sd3, 48'd10, 2'b11, 1, 48'd4, 1, 1'b1);
    drive(1, 1, 18'sd1, 18'sd1, 48'd0, 2'b11, 1, 48'hFFFF_FFFF_FFFF, 1, 1'b0);
    // CE stall with garbage on the inputs
    drive(1, 1, 18'sd5, 18'sd5, '0, 2'b00, 1, 48'd25);
    for (int i = 0; i < 3; i++) drive(0, 1, 18'sd9, 18'sd9, 48'd77, 2'b10);
    drive(1, 1, 18'sd2, 18'sd2, '0, 2'b01, 1, 48'd29);
    // invalid bubble
    drive(1, 0, 18'sd7, 18'sd7, '0, 2'b01);
    drive(1, 0, 18'sd7, 18'sd7, '0, 2'b01);
    // overflow sequence
    drive(1, 1, 18'sd1, 18'sd1, 48'h7FFF_FFFF_FFFF, 2'b10, 1, 48'h8000_0000_0000);
    drive(1, 1, 18'sd1, 18'sd1, '0, 2'b01, 1, 48'h8000_0000_0001);
    drive(1, 1, 18'sd3, 18'sd1, '0, 2'b00, 1, 48'd3);
    for (int i = 0; i < 3; i++) drive(1, 0, '0, '0, '0, 2'b00);

    // asynchronous reset with one op in flight
    drive(1, 1, 18'sd100, 18'sd100, '0, 2'b00);
    @(posedge CLK); #1;
    CE = 1'b1; IN_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    check("arst_p", 64'(P), 64'd0);
    check("arst_co", 64'(CARRYOUT), 64'd0);
    check("arst_valid", 64'(OUT_VALID), 64'd0);
`ifdef DSP_OVERFLOW_EN
    check("arst_ovf", 64'(OVERFLOW), 64'd0);
`endif
    q.delete();
    mp = '0; movf = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) drive(1, 0, '0, '0, '0, 2'b00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ra = 18'($urandom);
      rb = 18'($urandom);
      if ($urandom_range(0, 9) == 0) begin ra = -18'sd131072; rb = -18'sd131072; end
      r64 = {$urandom, $urandom};
      rc  = r64[PW-1:0];
      case ($urandom_range(0, 7))
        0: rc = 48'h7FFF_FFFF_FFFF;
        1: rc = 48'h8000_0000_0000;
        2: rc = '0;
        3: rc = '1;
        default: ;
      endcase
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, ra, rb, rc,
            ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 4; i++) drive(1, 0, '0, '0, '0, 2'b00);
    @(posedge CLK); @(negedge CLK);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
